line_window_3row: RTL

- Upstream neighbour of the R2 row-sum/cumulative controller and datapath.
- Converts a raster pixel stream (one pixel per accepted beat) into vertically aligned 3-pixel columns: rows r-2, r-1 and r at the same column.
- Emits the column-valid strobe, row/column position and an end-of-frame pulse. The R2 stage uses that pulse as its done_i start trigger and the positions as its row/column counters.

---
 rtl/line_window_3row_if.sv | 27 ++
 rtl/line_window_3row.sv | 115 +++++++++++
 2 files changed

// File: rtl/line_window_3row_if.sv
// Pixel-in / column-out bundle of the 3-row line window.
// The slave modport is the window block; the master modport is the pixel source and column consumer.
interface line_window_3row_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_top;
    logic [DATA_WIDTH-1:0] o_mid;
    logic [DATA_WIDTH-1:0] o_bot;
    logic                  o_valid;
    logic [9:0]            o_row;
    logic [9:0]            o_col;
    logic                  o_frame_done;

    // A pixel moves on a cycle with i_valid & o_ready. The source holds i_data/i_valid until then.
    // o_valid is a one-cycle strobe and cannot be stalled: the consumer takes every column it sees.
    modport slave (
        input  i_data, i_valid,
        output o_ready, o_top, o_mid, o_bot, o_valid, o_row, o_col, o_frame_done
    );
    modport master (
        output i_data, i_valid,
        input  o_ready, o_top, o_mid, o_bot, o_valid, o_row, o_col, o_frame_done
    );
endinterface

// File: rtl/line_window_3row.sv
// Turns a raster pixel stream into vertically aligned 3-pixel columns (rows r-2, r-1, r).
// Two line memories delay each pixel by one and two rows.
module line_window_3row #(
    parameter int COLS       = 7,
    parameter int ROWS       = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    line_window_3row_if.slave    bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

    localparam int         CW       = $clog2(COLS);
    localparam logic [9:0] LAST_COL = 10'(COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(ROWS - 1);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_line0 [COLS];
    logic [DATA_WIDTH-1:0] r_line1 [COLS];
    logic [9:0]            r_c;
    logic [9:0]            r_r;
    logic [DATA_WIDTH-1:0] r_top;
    logic [DATA_WIDTH-1:0] r_mid;
    logic [DATA_WIDTH-1:0] r_bot;
    logic [9:0]            r_row;
    logic [9:0]            r_col;
    logic                  r_valid;
    logic                  r_frame_done;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic [CW-1:0]         w_idx;

    assign w_ready    = ~rst & (r_state != S_DONE);
    assign w_accept   = bus.i_valid & w_ready;
    assign w_col_last = (r_c == LAST_COL);
    assign w_row_last = (r_r == LAST_ROW);
    assign w_idx      = r_c[CW-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_FILL;
            S_FILL:   if (w_accept && r_r == 10'd1 && w_col_last) w_next = S_STREAM;
            S_STREAM: if (w_accept && w_row_last && w_col_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Row counter wraps on the frame's last pixel so IDLE always starts at c=r=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c <= '0;
            r_r <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_c <= '0;
                r_r <= w_row_last ? 10'd0 : r_r + 10'd1;
            end else begin
                r_c <= r_c + 10'd1;
            end
        end
    end

    // No reset: rows 0 and 1 of every frame overwrite both lines before they are read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line1[w_idx] <= r_line0[w_idx];
            r_line0[w_idx] <= bus.i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top        <= '0;
            r_mid        <= '0;
            r_bot        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= w_accept && (r_state == S_STREAM);
            r_frame_done <= w_accept && (r_state == S_STREAM) && w_row_last && w_col_last;
            if (w_accept) begin
                r_bot <= bus.i_data;
                r_mid <= r_line0[w_idx];
                r_top <= r_line1[w_idx];
                r_row <= r_r;
                r_col <= r_c;
            end
        end
    end

    assign bus.o_ready      = w_ready;
    assign bus.o_top        = r_top;
    assign bus.o_mid        = r_mid;
    assign bus.o_bot        = r_bot;
    assign bus.o_row        = r_row;
    assign bus.o_col        = r_col;
    assign bus.o_valid      = r_valid;
    assign bus.o_frame_done = r_frame_done;
    assign o_dbg_state      = r_state;
endmodule
